// File: rtl/key_select_debouncer.sv
// Pushbutton conditioner for the 2-to-1 mux lab: synchronises an active-low key,
// rejects bounce, and turns each accepted press into a one-cycle pulse and a toggled select.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   UP        | key released and stable; waiting for a low sample
//   DOWN_PEND | key seen low; qualifying, any high sample aborts to UP
//   DOWN      | press accepted; key held
//   UP_PEND   | key seen high; qualifying release, any low sample back to DOWN
module key_select_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       btn_clean,
    output logic       press_pulse,
    output logic       sel,
    output logic [7:0] press_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        UP        = 2'd0,
        DOWN_PEND = 2'd1,
        DOWN      = 2'd2,
        UP_PEND   = 2'd3
    } state_t;

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_clean_q;
    logic             press_pulse_q;
    logic             sel_q;
    logic [7:0]       press_count_q;

    // Both stages reset to "released" so a key held through reset is re-qualified.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= key_n;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= UP;
            cnt_q         <= '0;
            btn_clean_q   <= 1'b0;
            press_pulse_q <= 1'b0;
            sel_q         <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            press_pulse_q <= 1'b0;
            case (state_q)
                UP: begin
                    if (!s2_q) begin
                        state_q <= DOWN_PEND;
                        cnt_q   <= '0;
                    end
                end
                DOWN_PEND: begin
                    if (s2_q) begin
                        state_q <= UP;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= DOWN;
                        btn_clean_q   <= 1'b1;
                        press_pulse_q <= 1'b1;
                        sel_q         <= ~sel_q;
                        press_count_q <= press_count_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (s2_q) begin
                        state_q <= UP_PEND;
                        cnt_q   <= '0;
                    end
                end
                UP_PEND: begin
                    if (!s2_q) begin
                        state_q <= DOWN;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= UP;
                        btn_clean_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= UP;
                    btn_clean_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_clean   = btn_clean_q;
    assign press_pulse = press_pulse_q;
    assign sel         = sel_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_key_select_debouncer.sv
// Directed bench for key_select_debouncer at DEBOUNCE_CYCLES=16; every press or
// release is expected to resolve on the 18th edge after the key first settles.
module tb_key_select_debouncer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic       btn_clean;
    logic       press_pulse;
    logic       sel;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    key_select_debouncer #(.DEBOUNCE_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .btn_clean   (btn_clean),
        .press_pulse (press_pulse),
        .sel         (sel),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released 1 ns after a rising edge; the next edge is sample 0.
    task automatic apply_reset();
        key_n = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL reset_btn_clean: got %b expected 0", btn_clean); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_press_pulse: got %b expected 0", press_pulse); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", sel); end
        checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", press_count); end
        reset = 1'b0;
        key_n = 1'b0;
        repeat (30) tick();
        checks++; if (btn_clean !== 1'b1) begin errors++; $display("FAIL pre_reset_held: got %b expected 1", btn_clean); end
        #2 reset = 1'b1;
        #1;
        checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL async_btn_clean: got %b expected 0", btn_clean); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL async_press_pulse: got %b expected 0", press_pulse); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL async_sel: got %b expected 0", sel); end
        checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", press_count); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL held_reset_early_pulse: edge %0d got %b expected 0", i, press_pulse); end
        end
        tick();
        checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL held_reset_pulse: got %b expected 1", press_pulse); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL held_reset_sel: got %b expected 1", sel); end
        checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL held_reset_count: got %0d expected 1", press_count); end
        key_n = 1'b1;
        repeat (40) tick();
    endtask

    task automatic test_clean_press();
        apply_reset();
        key_n = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++; if (press_pulse !== 1'b0 || btn_clean !== 1'b0) begin errors++; $display("FAIL clean_early: edge %0d got pulse=%b clean=%b expected 0/0", i, press_pulse, btn_clean); end
        end
        tick();
        checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL clean_pulse: got %b expected 1", press_pulse); end
        checks++; if (btn_clean !== 1'b1) begin errors++; $display("FAIL clean_level: got %b expected 1", btn_clean); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL clean_sel: got %b expected 1", sel); end
        checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL clean_count: got %0d expected 1", press_count); end
        for (int i = 0; i < 21; i++) begin
            tick();
            checks++; if (press_pulse !== 1'b0 || btn_clean !== 1'b1) begin errors++; $display("FAIL clean_hold: cycle %0d got pulse=%b clean=%b expected 0/1", i, press_pulse, btn_clean); end
        end
        key_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++; if (btn_clean !== 1'b1) begin errors++; $display("FAIL clean_release_early: edge %0d got %b expected 1", i, btn_clean); end
        end
        tick();
        checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL clean_release: got %b expected 0", btn_clean); end
        checks++; if (sel !== 1'b1 || press_count !== 8'd1) begin errors++; $display("FAIL clean_after_release: got sel=%b count=%0d expected 1/1", sel, press_count); end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int seg = 0; seg < 10; seg++) begin
            key_n = (seg % 2 == 1);
            repeat (3) begin
                tick();
                checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL bounce_spurious_pulse: segment %0d got %b expected 0", seg, press_pulse); end
            end
        end
        key_n = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL bounce_early_pulse: edge %0d got %b expected 0", i, press_pulse); end
        end
        tick();
        checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL bounce_pulse: got %b expected 1", press_pulse); end
        checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", press_count); end
        for (int seg = 0; seg < 4; seg++) begin
            key_n = (seg % 2 == 0);
            repeat (5) begin
                tick();
                checks++; if (press_pulse !== 1'b0 || btn_clean !== 1'b1) begin errors++; $display("FAIL release_glitch: segment %0d got pulse=%b clean=%b expected 0/1", seg, press_pulse, btn_clean); end
            end
        end
        key_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++; if (btn_clean !== 1'b1 || press_pulse !== 1'b0) begin errors++; $display("FAIL release_settle_early: edge %0d got clean=%b pulse=%b expected 1/0", i, btn_clean, press_pulse); end
        end
        tick();
        checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL release_settle: got %b expected 0", btn_clean); end
        checks++; if (sel !== 1'b1 || press_count !== 8'd1) begin errors++; $display("FAIL release_no_toggle: got sel=%b count=%0d expected 1/1", sel, press_count); end
    endtask

    task automatic test_short_glitch();
        apply_reset();
        key_n = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (i == 15) key_n = 1'b1;
            tick();
            checks++;
            if (btn_clean !== 1'b0 || press_pulse !== 1'b0 || sel !== 1'b0 || press_count !== 8'd0) begin
                errors++;
                $display("FAIL short_glitch: cycle %0d got clean=%b pulse=%b sel=%b count=%0d expected all 0", i, btn_clean, press_pulse, sel, press_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            key_n = 1'b0;
            repeat (18) begin tick(); if (press_pulse === 1'b1) pulses++; end
            key_n = 1'b1;
            repeat (18) begin tick(); if (press_pulse === 1'b1) pulses++; end
        end
        repeat (20) begin tick(); if (press_pulse === 1'b1) pulses++; end
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
        checks++; if (press_count !== 8'd3 || sel !== 1'b1) begin errors++; $display("FAIL b2b_state: got count=%0d sel=%b expected 3/1", press_count, sel); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        apply_reset();
        for (int p = 0; p < 257; p++) begin
            key_n = 1'b0;
            repeat (20) begin tick(); if (press_pulse === 1'b1) pulses++; end
            key_n = 1'b1;
            repeat (20) begin tick(); if (press_pulse === 1'b1) pulses++; end
            if (p == 255) begin
                checks++; if (press_count !== 8'd0 || sel !== 1'b0) begin errors++; $display("FAIL wrap_256: got count=%0d sel=%b expected 0/0", press_count, sel); end
            end
        end
        checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", press_count); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL wrap_sel: got %b expected 1", sel); end
        checks++; if (pulses != 257) begin errors++; $display("FAIL wrap_pulses: got %0d expected 257", pulses); end
    endtask

    task automatic test_hold();
        int pulses = 0;
        int low_seen = 0;
        apply_reset();
        key_n = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (press_pulse === 1'b1) pulses++;
            if (i >= 18 && btn_clean !== 1'b1) low_seen++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
        checks++; if (low_seen != 0) begin errors++; $display("FAIL hold_level: got %0d cycles low expected 0", low_seen); end
        key_n = 1'b1;
        repeat (20) tick();
        checks++; if (btn_clean !== 1'b0 || press_count !== 8'd1) begin errors++; $display("FAIL hold_release: got clean=%b count=%0d expected 0/1", btn_clean, press_count); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_glitch();
        test_back_to_back();
        test_wrap();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_select_debouncer.md
# key_select_debouncer

Upstream conditioning stage for the 7400-series 2-to-1 multiplexer lab: takes a raw, bouncing, active-low pushbutton and produces a clean toggling select bit. That bit drives the multiplexer's `s` input in place of a bare slide switch. The block synchronises the button, rejects bounce with a qualification counter, and emits a single-cycle press pulse. It also counts accepted presses for display on LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronised samples needed to accept a level change.
  - Legal range 2..2^20.
  - Board top overrides to 1_000_000 (20 ms at 50 MHz).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately, independent of `clk`.
- `key_n` input 1: raw pushbutton, active-low (0 = pressed); asynchronous to `clk`; may bounce.
- `btn_clean` output 1: debounced button level, active-high (1 = held).
- `press_pulse` output 1: high for exactly one `clk` cycle per accepted press.
- `sel` output 1: select bit for the downstream mux; toggles on every accepted press.
- `press_count` output 8: accepted presses modulo 256.

## Operation
- **Synchroniser**
  - Two flops in series: `key_n` → `s1` → `s2`.
  - Both flops reset to 1 (released).
  - The FSM only ever looks at `s2`.
- **Counter**
  - `cnt` has width ceil(log2(DEBOUNCE_CYCLES)).
  - It resets to 0 and is cleared to 0 on entry to either PEND state.
- **FSM states** (reset state UP):
  - UP:
    - `btn_clean`=0.
    - `s2`==0 → DOWN_PEND, `cnt`←0.
    - Otherwise stay.
  - DOWN_PEND:
    - `btn_clean`=0.
    - `s2`==1 → UP (bounce rejected; no output change).
    - Else if `cnt`==DEBOUNCE_CYCLES-1 → DOWN, and on the same edge: `press_pulse`←1, `sel`←~`sel`, `press_count`←`press_count`+1.
    - Else `cnt`←`cnt`+1.
  - DOWN:
    - `btn_clean`=1.
    - `s2`==1 → UP_PEND, `cnt`←0.
    - Otherwise stay.
  - UP_PEND:
    - `btn_clean`=1.
    - `s2`==0 → DOWN (release bounce rejected; no pulse, no toggle).
    - Else if `cnt`==DEBOUNCE_CYCLES-1 → UP.
    - Else `cnt`←`cnt`+1.
- **Output rules**
  - `btn_clean` is registered: 1 exactly while state ∈ {DOWN, UP_PEND}.
  - `press_pulse` is registered: set only on the DOWN_PEND→DOWN edge, cleared on the following edge.
  - Holding the button never produces a second pulse.
  - `press_count` is 8-bit unsigned and wraps 255→0 with no flag.
  - Release never toggles `sel` or counts.
- **Reset values**
  - state=UP, `s1`=`s2`=1, `cnt`=0.
  - `btn_clean`=0, `press_pulse`=0, `sel`=0, `press_count`=0.
- **Reset mid-operation**
  - An in-flight qualification is discarded.
  - If the key is still held when `reset` falls, it goes through full synchronisation plus qualification and counts as a new press.

## Timing
- **Press latency**: with `key_n` stably 0 and first sampled at edge 0:
  - `s2`=0 after edge 1.
  - DOWN_PEND entered at edge 2.
  - DOWN entered at edge DEBOUNCE_CYCLES+2.
  - `btn_clean`, `press_pulse`, toggled `sel` and incremented `press_count` are all visible in the cycle after that edge.
- **Release latency**: symmetric, DEBOUNCE_CYCLES+2 edges to `btn_clean`=0.
- **Bounce rejection**: any `s2` excursion that lasts at most DEBOUNCE_CYCLES cycles is rejected and the qualification restarts from 0.
- **Minimum press-to-press spacing**: 2·(DEBOUNCE_CYCLES+2) cycles.
- **`sel` hold**: `sel` holds steady between pulses, so the downstream mux output changes at most once per accepted press.
- **Async reset**: `reset` acts within the same cycle with no clock required; release of reset is assumed synchronous to `clk` by the board reset synchroniser.

## Test plan
- **Reset**: assert `reset` mid-cycle with `key_n`=0 held → all outputs 0 immediately. Deassert reset, keep `key_n`=0 → one `press_pulse` at edge 18 after release (DEBOUNCE_CYCLES=16), `sel`=1, `press_count`=1.
- **Clean press/release**: `key_n` 1→0 for 40 cycles, then 1 →
  - `press_pulse` high for exactly 1 cycle, 18 edges after the first low sample;
  - `btn_clean` 1 for 40 cycles and falls 18 edges after release;
  - `sel` 0→1.
- **Bounce**: `key_n` toggles 0/1 every 3 cycles for 30 cycles, then settles at 0 → exactly one `press_pulse`, 18 edges after settling; `press_count`=1. A release with 5-cycle glitches back to 0 → no pulse, `sel` unchanged.
- **Short glitch**: a single 15-cycle low pulse on `key_n` → no state change, all outputs stay 0.
- **Wrap**: 257 clean presses → `press_count`=1, `sel`=1 (odd count), 257 pulses observed.
- **Hold**: `key_n`=0 for 1000 cycles → exactly one `press_pulse`; `btn_clean` stays 1 throughout after qualification.
